writeback_stage: RTL and testbench
==================================

Name: writeback_stage

Overview:
- Final pipeline stage. Sits directly downstream of the memory stage and consumes its load_data output.
- Holds the MEM/WB pipeline register and performs sub-word load extraction with sign/zero extension.
- Owns the 32-entry register file, with write-to-read bypass.
- Exports forwarding information for the hazard unit and a retired-instruction counter.

Parameters:
- DATA_W, 32, datapath width
- REG_AW, 5, register address width (2**REG_AW registers)
- CNT_W, 32, retire counter width

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  memory stage presents a valid instruction
- in_result  input  DATA_W  memory-stage load_data (raw load word or ALU result)
- in_addr_lo  input  2  low address bits of the access
- in_is_load  input  1  instruction is a load
- in_size  input  2  00 byte, 01 half, 10 word, 11 reserved
- in_unsigned  input  1  zero-extend sub-word load
- in_rd  input  REG_AW  destination register
- in_rd_we  input  1  instruction writes rd
- stall  input  1  upstream holding; WB must not capture
- flush  input  1  discard incoming instruction
- rs1_addr  input  REG_AW  read port 1 address
- rs2_addr  input  REG_AW  read port 2 address
- rs1_data  output  DATA_W  read port 1 data (combinational)
- rs2_data  output  DATA_W  read port 2 data (combinational)
- fwd_valid  output  1  WB entry will write a register this cycle
- fwd_rd  output  REG_AW  register being written
- fwd_data  output  DATA_W  value being written
- retired  output  1  pulse: WB entry committed this cycle
- misalign  output  1  pulse: committing load was misaligned
- retire_count  output  CNT_W  committed-instruction count

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the entry valid bit, all registers, and retire_count.
  - All outputs are 0 during and after reset.
  - Reset mid-operation drops the held entry; no write occurs.
- Capture, on each rising clk:
  - If stall=0, flush=0 and in_valid=1: load entry fields from the inputs; valid<=1.
  - Otherwise: valid<=0 (bubble). flush has priority over in_valid; stall has priority over flush.
- Commit:
  - An entry with valid=1 commits in the cycle after capture (latency 1 edge in, write on next edge).
  - Each entry commits exactly once; stall never causes a repeat write.
  - An older entry already in WB still commits when flush or stall is asserted.
- Extraction (combinational from the entry):
  - Non-load: value = result unchanged; size is ignored.
  - Byte load: lane = addr_lo (little-endian); bits [8*lane+7:8*lane], sign-extended unless unsigned.
  - Half load: addr_lo[1] selects the half; addr_lo[0]=1 is misaligned.
  - Word load: addr_lo must be 00; any other value is misaligned. Size 11 is also misaligned.
- Write enable = valid & rd_we & (rd != 0) & !misaligned_load.
- Register r0 always reads 0 and is never written.
- Read ports: if the read address equals the write address and write enable is active, return the write value (write-through bypass). Otherwise return the array contents.
- fwd_valid = write enable; fwd_rd and fwd_data reflect the entry. All are 0 when fwd_valid=0.
- retired:
  - High for the single cycle an entry is valid, including misaligned and rd_we=0 entries.
  - retire_count increments on the edge ending that cycle and wraps modulo 2**CNT_W.
- misalign = valid & is_load & misaligned. The register is not written; the entry still retires.

Decomposition:
- Shared cpu_pkg:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD
  - REG_ZERO constant
  - DATA_W/REG_AW defaults
  - MEM/WB entry struct (result, addr_lo, is_load, size, unsigned, rd, rd_we)
- One sub-module reg_file:
  - 2 combinational read ports, 1 synchronous write port, r0 hardwired, bypass inside.
  - Asynchronous active-low reset of the array.
- Extraction logic stays inline.

Test Plan:
- Reset then read all regs -> rs1_data=rs2_data=0; retire_count=0; fwd_valid=0.
- ALU op: result=0xDEADBEEF, rd=5, rd_we=1 -> next cycle fwd_valid=1, fwd_rd=5; afterwards r5 reads 0xDEADBEEF; retire_count=1.
- Byte load: result=0x80FF7F01.
  - addr_lo=3 signed -> r6=0xFFFFFF80.
  - addr_lo=1 unsigned -> r6=0x0000007F.
  - Half load, addr_lo=2 signed -> r6=0xFFFF80FF.
- Misaligned word load, addr_lo=2, rd=7 -> misalign=1 for one cycle, r7 unchanged, retired=1.
- Bypass: commit rd=3 value 0x1234 while rs1_addr=3 -> rs1_data=0x1234 the same cycle. A write to rd=0 leaves r0=0.
- Stall/flush:
  - in_valid=1 with stall=1 for 3 cycles -> exactly one commit of the prior entry, no duplicate.
  - flush with in_valid=1 -> no commit, retire_count unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, load-size encodings and the
// MEM/WB pipeline entry.
package cpu_pkg;

  localparam int unsigned CPU_DATA_W = 32;
  localparam int unsigned CPU_REG_AW = 5;
  localparam logic [CPU_REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef struct packed {
    logic [CPU_DATA_W-1:0] result;
    logic [1:0]            addr_lo;
    logic                  is_load;
    size_e                 size;
    logic                  is_unsigned;
    logic [CPU_REG_AW-1:0] rd;
    logic                  rd_we;
  } mem_wb_t;

endpackage

// File: rtl/writeback_stage_reg_file.sv
// Register file: two combinational read ports with write-through bypass,
// one synchronous write port, r0 hardwired to zero.
module reg_file
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned REG_AW = CPU_REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem [2**REG_AW];
  logic              wr_act;

  assign wr_act = we && (waddr != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < 2**REG_AW; i++) mem[REG_AW'(i)] <= '0;
    end else if (wr_act) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (raddr1 != '0) rdata1 = (wr_act && raddr1 == waddr) ? wdata : mem[raddr1];
  end

  always_comb begin
    rdata2 = '0;
    if (raddr2 != '0) rdata2 = (wr_act && raddr2 == waddr) ? wdata : mem[raddr2];
  end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: MEM/WB register, sub-word load extraction, register file
// commit, forwarding export and retired-instruction counter.
module writeback_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = CPU_DATA_W,
  parameter int unsigned REG_AW = CPU_REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_result,
  input  logic [1:0]        in_addr_lo,
  input  logic              in_is_load,
  input  logic [1:0]        in_size,
  input  logic              in_unsigned,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs1_addr,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic [DATA_W-1:0] rs2_data,
  output logic              fwd_valid,
  output logic [REG_AW-1:0] fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              retired,
  output logic              misalign,
  output logic [CNT_W-1:0]  retire_count
);

  mem_wb_t           entry;
  logic              valid;
  logic [DATA_W-1:0] value;
  logic              mis;
  logic              we;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;

  // stall outranks flush, flush outranks in_valid; anything else is a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid        <= 1'b0;
      entry        <= '0;
      retire_count <= '0;
    end else begin
      if (valid) retire_count <= retire_count + 1'b1;
      if (!stall && !flush && in_valid) begin
        valid <= 1'b1;
        entry <= '{result: in_result, addr_lo: in_addr_lo, is_load: in_is_load,
                   size: size_e'(in_size), is_unsigned: in_unsigned,
                   rd: in_rd, rd_we: in_rd_we};
      end else begin
        valid <= 1'b0;
      end
    end
  end

  assign byte_sel = entry.result[{entry.addr_lo, 3'b000} +: 8];
  assign half_sel = entry.result[{entry.addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    value = entry.result;
    mis   = 1'b0;
    if (entry.is_load) begin
      case (entry.size)
        SIZE_BYTE: value = {{(DATA_W-8){byte_sel[7] & ~entry.is_unsigned}}, byte_sel};
        SIZE_HALF: begin
          value = {{(DATA_W-16){half_sel[15] & ~entry.is_unsigned}}, half_sel};
          mis   = entry.addr_lo[0];
        end
        SIZE_WORD: mis = (entry.addr_lo != 2'b00);
        default:   mis = 1'b1;
      endcase
    end
  end

  assign we        = valid && entry.rd_we && (entry.rd != REG_ZERO) && !mis;
  assign fwd_valid = we;
  assign fwd_rd    = we ? entry.rd : '0;
  assign fwd_data  = we ? value : '0;
  assign retired   = valid;
  assign misalign  = valid && entry.is_load && mis;

  reg_file #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (entry.rd),
    .wdata  (value),
    .raddr1 (rs1_addr),
    .rdata1 (rs1_data),
    .raddr2 (rs2_addr),
    .rdata2 (rs2_data)
  );

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for single instructions
// plus hand sequences for bypass, stall, flush and mid-operation reset.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_result;
  logic [1:0]  in_addr_lo;
  logic        in_is_load;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic        stall;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        retired;
  logic        misalign;
  logic [31:0] retire_count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_count = 0;

  always #5 clk = ~clk;

  writeback_stage #(
    .DATA_W (32),
    .REG_AW (5),
    .CNT_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_result    (in_result),
    .in_addr_lo   (in_addr_lo),
    .in_is_load   (in_is_load),
    .in_size      (in_size),
    .in_unsigned  (in_unsigned),
    .in_rd        (in_rd),
    .in_rd_we     (in_rd_we),
    .stall        (stall),
    .flush        (flush),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .fwd_valid    (fwd_valid),
    .fwd_rd       (fwd_rd),
    .fwd_data     (fwd_data),
    .retired      (retired),
    .misalign     (misalign),
    .retire_count (retire_count)
  );

  typedef struct {
    logic [31:0] result;
    logic [1:0]  addr_lo;
    logic        is_load;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic        rd_we;
    logic        exp_we;
    logic [31:0] exp_val;
    logic        exp_mis;
    logic [31:0] exp_reg;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [31:0] result, input logic [1:0] addr_lo,
                              input logic is_load, input logic [1:0] size, input logic uns,
                              input logic [4:0] rd, input logic rd_we, input logic exp_we,
                              input logic [31:0] exp_val, input logic exp_mis,
                              input logic [31:0] exp_reg);
    vec_t v;
    v.result = result;  v.addr_lo = addr_lo; v.is_load = is_load; v.size = size;
    v.uns = uns;        v.rd = rd;           v.rd_we = rd_we;     v.exp_we = exp_we;
    v.exp_val = exp_val; v.exp_mis = exp_mis; v.exp_reg = exp_reg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [31:0] result, input logic [1:0] addr_lo,
                       input logic is_load, input logic [1:0] size, input logic uns,
                       input logic [4:0] rd, input logic rd_we);
    in_result = result; in_addr_lo = addr_lo; in_is_load = is_load;
    in_size = size; in_unsigned = uns; in_rd = rd; in_rd_we = rd_we;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.result, v.addr_lo, v.is_load, v.size, v.uns, v.rd, v.rd_we);
    in_valid = 1'b1;
    rs1_addr = v.rd;
    rs2_addr = v.rd;
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d retired", idx), 32'(retired), 32'd1);
    chk($sformatf("v%0d fwd_valid", idx), 32'(fwd_valid), 32'(v.exp_we));
    chk($sformatf("v%0d fwd_rd", idx), 32'(fwd_rd), v.exp_we ? 32'(v.rd) : 32'd0);
    chk($sformatf("v%0d fwd_data", idx), fwd_data, v.exp_we ? v.exp_val : 32'd0);
    chk($sformatf("v%0d misalign", idx), 32'(misalign), 32'(v.exp_mis));
    exp_count++;
    @(negedge clk);
    chk($sformatf("v%0d rs1_data", idx), rs1_data, v.exp_reg);
    chk($sformatf("v%0d rs2_data", idx), rs2_data, v.exp_reg);
    chk($sformatf("v%0d retire_count", idx), retire_count, 32'(exp_count));
    chk($sformatf("v%0d retired_after", idx), 32'(retired), 32'd0);
  endtask

  initial begin
    int pulses;

    //               result        lo   ld    sz     u     rd     we    ewe   exp_val       mis   exp_reg
    vecs[0]  = mk(32'hDEADBEEF, 2'd0, 1'b0, 2'b10, 1'b0, 5'd5,  1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF);
    vecs[1]  = mk(32'h80FF7F01, 2'd3, 1'b1, 2'b00, 1'b0, 5'd6,  1'b1, 1'b1, 32'hFFFFFF80, 1'b0, 32'hFFFFFF80);
    vecs[2]  = mk(32'h80FF7F01, 2'd1, 1'b1, 2'b00, 1'b1, 5'd6,  1'b1, 1'b1, 32'h0000007F, 1'b0, 32'h0000007F);
    vecs[3]  = mk(32'h80FF7F01, 2'd2, 1'b1, 2'b01, 1'b0, 5'd6,  1'b1, 1'b1, 32'hFFFF80FF, 1'b0, 32'hFFFF80FF);
    vecs[4]  = mk(32'h80FF7F01, 2'd2, 1'b1, 2'b10, 1'b0, 5'd7,  1'b1, 1'b0, 32'h0,        1'b1, 32'h0);
    vecs[5]  = mk(32'h80FF7F01, 2'd0, 1'b1, 2'b00, 1'b0, 5'd8,  1'b1, 1'b1, 32'h00000001, 1'b0, 32'h00000001);
    vecs[6]  = mk(32'h1234ABCD, 2'd0, 1'b1, 2'b01, 1'b1, 5'd9,  1'b1, 1'b1, 32'h0000ABCD, 1'b0, 32'h0000ABCD);
    vecs[7]  = mk(32'h1234ABCD, 2'd1, 1'b1, 2'b01, 1'b0, 5'd9,  1'b1, 1'b0, 32'h0,        1'b1, 32'h0000ABCD);
    vecs[8]  = mk(32'h55555555, 2'd0, 1'b1, 2'b11, 1'b0, 5'd10, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0);
    vecs[9]  = mk(32'hCAFEF00D, 2'd3, 1'b0, 2'b00, 1'b0, 5'd11, 1'b1, 1'b1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D);
    vecs[10] = mk(32'h00000005, 2'd0, 1'b0, 2'b10, 1'b0, 5'd12, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[11] = mk(32'hFFFFFFFF, 2'd0, 1'b0, 2'b10, 1'b0, 5'd0,  1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[12] = mk(32'h89ABCDEF, 2'd0, 1'b1, 2'b10, 1'b1, 5'd13, 1'b1, 1'b1, 32'h89ABCDEF, 1'b0, 32'h89ABCDEF);

    rst = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    drive('0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    rs1_addr = '0; rs2_addr = '0;

    // Reset state
    #2;
    for (int r = 0; r < 32; r++) begin
      rs1_addr = 5'(r);
      rs2_addr = 5'(31 - r);
      #1;
      chk($sformatf("reset rs1 r%0d", r), rs1_data, 32'd0);
      chk($sformatf("reset rs2 r%0d", 31 - r), rs2_data, 32'd0);
    end
    chk("reset retire_count", retire_count, 32'd0);
    chk("reset fwd_valid", 32'(fwd_valid), 32'd0);
    chk("reset retired", 32'(retired), 32'd0);
    chk("reset misalign", 32'(misalign), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);
    rs1_addr = 5'd0;
    #1 chk("r0 reads zero", rs1_data, 32'd0);

    // Bypass: read port sees the value in the cycle it is being written
    @(negedge clk);
    drive(32'h00001234, 2'd0, 1'b0, 2'b10, 1'b0, 5'd3, 1'b1);
    in_valid = 1'b1;
    rs1_addr = 5'd3;
    rs2_addr = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("bypass rs1", rs1_data, 32'h00001234);
    chk("bypass rs2 other", rs2_data, 32'hDEADBEEF);
    exp_count++;
    @(negedge clk);
    chk("bypass r3 stored", rs1_data, 32'h00001234);

    // Stall: prior entry commits once, stalled instruction never captured
    @(negedge clk);
    drive(32'h00000111, 2'd0, 1'b0, 2'b10, 1'b0, 5'd14, 1'b1);
    in_valid = 1'b1;
    rs1_addr = 5'd14;
    pulses = 0;
    @(negedge clk);
    if (retired) pulses++;
    stall = 1'b1;
    drive(32'h00000222, 2'd0, 1'b0, 2'b10, 1'b0, 5'd14, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (retired) pulses++;
    end
    stall = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    if (retired) pulses++;
    exp_count++;
    chk("stall retire pulses", 32'(pulses), 32'd1);
    chk("stall r14", rs1_data, 32'h00000111);
    chk("stall retire_count", retire_count, 32'(exp_count));

    // Flush: older entry still commits, flushed instruction is dropped
    @(negedge clk);
    drive(32'h0000AAAA, 2'd0, 1'b0, 2'b10, 1'b0, 5'd15, 1'b1);
    in_valid = 1'b1;
    rs1_addr = 5'd15;
    @(negedge clk);
    chk("flush older retired", 32'(retired), 32'd1);
    flush = 1'b1;
    drive(32'h0000BBBB, 2'd0, 1'b0, 2'b10, 1'b0, 5'd15, 1'b1);
    exp_count++;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush no retire", 32'(retired), 32'd0);
    chk("flush fwd_valid", 32'(fwd_valid), 32'd0);
    @(negedge clk);
    chk("flush r15", rs1_data, 32'h0000AAAA);
    chk("flush retire_count", retire_count, 32'(exp_count));

    // Reset mid-operation drops the held entry
    drive(32'h0000CCCC, 2'd0, 1'b0, 2'b10, 1'b0, 5'd17, 1'b1);
    in_valid = 1'b1;
    rs1_addr = 5'd17;
    rs2_addr = 5'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre-reset fwd_valid", 32'(fwd_valid), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid-reset retired", 32'(retired), 32'd0);
    chk("mid-reset fwd_valid", 32'(fwd_valid), 32'd0);
    chk("mid-reset retire_count", retire_count, 32'd0);
    chk("mid-reset r5", rs2_data, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-reset r17", rs1_data, 32'd0);
    chk("post-reset retire_count", retire_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
